puf_cmd_ctrl: RTL and testbench
===============================

Name: puf_cmd_ctrl

Overview:
- Frame-level controller on the UART receive path of the PUF interface.
- Watches the UART receiver's parallel byte and ready level, and qualifies each completed byte.
- Sequences bytes through a fixed frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Presents a checked command plus challenge vector to the PUF core over a valid/ack handshake.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 8: maximum payload bytes (1..255); sets challenge width.
- MIN_LOW_CYC, 64: minimum cycles rec_readyH must stay low for a byte to count (noise rejection).
- TIMEOUT_CYC, 4096: inter-byte timeout in sys_clk cycles (see optional feature).

Ports:
- sys_clk  in  1  system clock, 16x baud.
- sys_rstH  in  1  synchronous, active-high reset.
- rec_dataH  in  8  parallel byte from the UART receiver.
- rec_readyH  in  1  receiver ready level: high while idle, low while a byte is being received.
- cmd_ackH  in  1  consumer accepts the pending command.
- cmd_validH  out  1  command pending; held until acked.
- cmd_opH  out  8  CMD byte.
- cmd_lenH  out  8  LEN byte.
- challengeH  out  MAX_LEN*8  payload; byte i at [8i+7:8i].
- busyH  out  1  frame in progress (any state other than IDLE or PEND).
- err_lenH  out  1  one-cycle pulse: LEN > MAX_LEN.
- err_chkH  out  1  one-cycle pulse: checksum mismatch.
- err_ovrH  out  1  one-cycle pulse: byte arrived while PEND.
- err_toH  out  1  one-cycle pulse: inter-byte timeout.

Behaviour:
- Reset: all outputs 0, challengeH 0, state IDLE, armed 0, rdy_q 1.
- Clock and reset: one clock; reset is synchronous and active-high.

Byte qualification:
- rdy_q registers rec_readyH.
- Falling edge (rdy_q=1, rec_readyH=0): set armed, clear low counter. Low counter saturates at MIN_LOW_CYC.
- Rising edge with armed=1 and low count >= MIN_LOW_CYC: byte_stb for one cycle, capture rec_dataH the same cycle, clear armed.
- Rising edge with armed=0 (e.g. receiver's post-reset 0->1 transition), or with too short a low period: ignored, no strobe.

Frame state machine (evaluated on byte_stb):
- IDLE: byte == SYNC_BYTE -> GET_CMD; zero challengeH; chk_acc = 0. Any other byte is silently dropped.
- GET_CMD: latch cmd_opH; chk_acc ^= byte; -> GET_LEN.
- GET_LEN:
  - byte > MAX_LEN: pulse err_lenH, -> IDLE.
  - Otherwise: latch cmd_lenH; chk_acc ^= byte; idx = 0; -> GET_PAY if LEN > 0, else GET_CHK.
- GET_PAY: store byte at challengeH[idx]; chk_acc ^= byte; idx++; when idx reaches LEN-1 on this byte -> GET_CHK.
- GET_CHK: byte == chk_acc -> PEND with cmd_validH = 1 next cycle; otherwise pulse err_chkH, -> IDLE.
- PEND:
  - cmd_validH, cmd_opH, cmd_lenH and challengeH are held stable.
  - cmd_ackH: clear cmd_validH, -> IDLE next cycle.
  - byte_stb without ack: pulse err_ovrH, byte discarded.
  - byte_stb and cmd_ackH in the same cycle: ack wins. The byte is evaluated as an IDLE byte, so a SYNC goes directly to GET_CMD.

Timing and corner cases:
- Latency: cmd_validH asserts 1 cycle after the CHK byte_stb.
- cmd_ackH while not PEND: ignored.
- sys_rstH mid-frame: immediate return to IDLE, partial frame discarded, no error pulse.
- idx width is clog2(MAX_LEN)+1; no wrap is possible because LEN <= MAX_LEN is enforced.

Optional Feature:
- Macro: PUF_CMD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every byte_stb and counts while busyH.
  - Reaching TIMEOUT_CYC: pulse err_toH, -> IDLE, discard partial frame.
  - Never fires in IDLE or PEND.
- Undefined: no counter; err_toH tied 0; frames may stall indefinitely.

Decomposition:
- Package puf_cmd_pkg holds:
  - state enum (IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK, PEND);
  - SYNC_BYTE default;
  - opcode constants (OP_CHALLENGE 8'h01, OP_READ 8'h02).
- Sub-module rx_byte_qual covers rdy_q, armed, the low counter and the byte_stb/data capture. It is reusable by any other consumer of the receiver.

Test Plan:
- Basic frame: post-reset, send A5 01 02 11 22 30 -> cmd_validH=1, cmd_opH=01, cmd_lenH=02, challengeH[15:0]=16'h2211, upper bytes 0. Hold 10 cycles, then ack -> cmd_validH 0 next cycle.
- Post-reset spurious ready edge: rec_readyH goes 0 then 1 immediately after reset -> no byte_stb, state remains IDLE.
- Errors:
  - A5 01 09 (MAX_LEN=8) -> err_lenH pulse, IDLE.
  - A5 01 01 55 00 -> err_chkH pulse (expected 55), cmd_validH stays 0.
- Noise rejection: rec_readyH low for 5 cycles then high -> no strobe. A following valid frame decodes correctly.
- PEND contention:
  - Send a byte while PEND -> err_ovrH pulse, held outputs unchanged.
  - SYNC strobe coincident with ack -> state GET_CMD.
- Timeout (PUF_CMD_TIMEOUT_EN): A5 01 then idle TIMEOUT_CYC cycles -> err_toH pulse, busyH 0. Without the macro: busyH stays 1, err_toH 0.

Source files
------------

// File: rtl/puf_cmd_pkg.sv
// ---------------------------------------------------------------------------
// puf_cmd_pkg
// Shared types and constants for the PUF command frame controller:
//   - state_e      : frame state machine encoding
//   - SYNC_BYTE_DEF: default frame start marker
//   - OP_*         : command opcodes understood by the PUF core
// ---------------------------------------------------------------------------
package puf_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAY,
    GET_CHK,
    PEND
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [7:0] OP_CHALLENGE  = 8'h01;
  localparam logic [7:0] OP_READ       = 8'h02;

endpackage

// File: rtl/rx_byte_qual.sv
// ---------------------------------------------------------------------------
// rx_byte_qual
// Turns the UART receiver's ready level into a one-cycle byte strobe. A byte
// counts only if ready fell (arming the qualifier) and then stayed low for at
// least MIN_LOW_CYC cycles before rising again; short glitches and the
// receiver's post-reset 0->1 transition produce no strobe.
//
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   rec_data_i   in   [7:0] parallel byte from the receiver
//   rec_ready_i  in   receiver ready level (low while receiving)
//   byte_stb_o   out  one-cycle strobe: qualified byte completes this cycle
//   byte_o       out  [7:0] byte captured with byte_stb_o
// ---------------------------------------------------------------------------
module rx_byte_qual #(
  parameter int MIN_LOW_CYC = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rec_data_i,
  input  logic       rec_ready_i,
  output logic       byte_stb_o,
  output logic [7:0] byte_o
);

  localparam int               CW      = $clog2(MIN_LOW_CYC + 1);
  localparam logic [CW-1:0]    LOW_SAT = CW'(MIN_LOW_CYC);

  logic          rdy_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic          fall, rise;

  assign fall = rdy_q & ~rec_ready_i;
  assign rise = ~rdy_q & rec_ready_i;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    armed_d   = armed_q;
    low_cnt_d = low_cnt_q;
    if (fall) begin
      armed_d   = 1'b1;
      low_cnt_d = '0;
    end else if (!rec_ready_i && low_cnt_q != LOW_SAT) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end
    if (rise) armed_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q     <= 1'b1;
      armed_q   <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      rdy_q     <= rec_ready_i;
      armed_q   <= armed_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign byte_stb_o = rise & armed_q & (low_cnt_q >= LOW_SAT);
  assign byte_o     = rec_data_i;

endmodule

// File: rtl/puf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// puf_cmd_ctrl
// Frame-level controller on the PUF UART receive path. Parses
//   SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN and payload)
// and presents the checked command over a valid/ack handshake.
//
// Optional feature: define PUF_CMD_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYC cycles without a byte; otherwise err_toH is tied low.
//
// Ports:
//   sys_clk     in   system clock (16x baud)
//   sys_rstH    in   synchronous active-high reset
//   rec_dataH   in   [7:0] receiver byte
//   rec_readyH  in   receiver ready level
//   cmd_ackH    in   consumer accepts the pending command
//   cmd_validH  out  command pending, held until acked
//   cmd_opH     out  [7:0] CMD byte
//   cmd_lenH    out  [7:0] LEN byte
//   challengeH  out  [MAX_LEN*8-1:0] payload, byte i at [8i+7:8i]
//   busyH       out  frame in progress
//   err_lenH    out  pulse: LEN > MAX_LEN
//   err_chkH    out  pulse: checksum mismatch
//   err_ovrH    out  pulse: byte arrived while a command was pending
//   err_toH     out  pulse: inter-byte timeout
// ---------------------------------------------------------------------------
module puf_cmd_ctrl
  import puf_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         MAX_LEN     = 8,
  parameter int         MIN_LOW_CYC = 64,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                 sys_clk,
  input  logic                 sys_rstH,
  input  logic [7:0]           rec_dataH,
  input  logic                 rec_readyH,
  input  logic                 cmd_ackH,
  output logic                 cmd_validH,
  output logic [7:0]           cmd_opH,
  output logic [7:0]           cmd_lenH,
  output logic [MAX_LEN*8-1:0] challengeH,
  output logic                 busyH,
  output logic                 err_lenH,
  output logic                 err_chkH,
  output logic                 err_ovrH,
  output logic                 err_toH
);

  localparam int IW = $clog2(MAX_LEN) + 1;

  logic       byte_stb;
  logic [7:0] byte_val;

  rx_byte_qual #(.MIN_LOW_CYC(MIN_LOW_CYC)) u_qual (
    .clk_i       (sys_clk),
    .rst_i       (sys_rstH),
    .rec_data_i  (rec_dataH),
    .rec_ready_i (rec_readyH),
    .byte_stb_o  (byte_stb),
    .byte_o      (byte_val)
  );

  state_e               state_q, state_d;
  logic [7:0]           chk_q, chk_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [7:0]           op_q, op_d;
  logic [7:0]           len_q, len_d;
  logic [MAX_LEN*8-1:0] chal_q, chal_d;
  logic                 valid_q, valid_d;
  logic                 err_len_q, err_len_d;
  logic                 err_chk_q, err_chk_d;
  logic                 err_ovr_q, err_ovr_d;
  logic                 err_to_q, err_to_d;
  logic                 busy;
  logic                 sync_hit;
  logic                 to_fire;

  assign busy     = (state_q != IDLE) && (state_q != PEND);
  assign sync_hit = byte_stb && (byte_val == SYNC_BYTE);

`ifdef PUF_CMD_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rstH || byte_stb || !busy || to_fire) to_cnt_q <= '0;
    else                                          to_cnt_q <= to_cnt_q + 16'd1;
  end

  // A byte arriving on the expiry cycle restarts the window instead.
  assign to_fire = busy && !byte_stb && (to_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    op_d      = op_q;
    len_d     = len_q;
    chal_d    = chal_q;
    valid_d   = valid_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    err_to_d  = 1'b0;

    unique case (state_q)
      IDLE: if (sync_hit) begin
        state_d = GET_CMD;
        chal_d  = '0;
        chk_d   = '0;
      end
      GET_CMD: if (byte_stb) begin
        op_d    = byte_val;
        chk_d   = chk_q ^ byte_val;
        state_d = GET_LEN;
      end
      GET_LEN: if (byte_stb) begin
        if (byte_val > 8'(MAX_LEN)) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else begin
          len_d   = byte_val;
          chk_d   = chk_q ^ byte_val;
          idx_d   = '0;
          state_d = (byte_val != 8'd0) ? GET_PAY : GET_CHK;
        end
      end
      GET_PAY: if (byte_stb) begin
        chal_d[8*int'(idx_q) +: 8] = byte_val;
        chk_d = chk_q ^ byte_val;
        idx_d = idx_q + 1'b1;
        if (8'(idx_q) == len_q - 8'd1) state_d = GET_CHK;
      end
      GET_CHK: if (byte_stb) begin
        if (byte_val == chk_q) begin
          valid_d = 1'b1;
          state_d = PEND;
        end else begin
          err_chk_d = 1'b1;
          state_d   = IDLE;
        end
      end
      PEND: begin
        // Ack has priority; a coincident byte is then treated as an IDLE byte.
        if (cmd_ackH) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (sync_hit) begin
            state_d = GET_CMD;
            chal_d  = '0;
            chk_d   = '0;
          end
        end else if (byte_stb) begin
          err_ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (to_fire) begin
      err_to_d = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      state_q   <= IDLE;
      chk_q     <= '0;
      idx_q     <= '0;
      op_q      <= '0;
      len_q     <= '0;
      chal_q    <= '0;
      valid_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      len_q     <= len_d;
      chal_q    <= chal_d;
      valid_q   <= valid_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
      err_to_q  <= err_to_d;
    end
  end

  assign cmd_validH = valid_q;
  assign cmd_opH    = op_q;
  assign cmd_lenH   = len_q;
  assign challengeH = chal_q;
  assign busyH      = busy;
  assign err_lenH   = err_len_q;
  assign err_chkH   = err_chk_q;
  assign err_ovrH   = err_ovr_q;
  assign err_toH    = err_to_q;

endmodule

// File: tb/tb_puf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_cmd_ctrl
// Self-checking bench for puf_cmd_ctrl. Expected commands are queued as
// frames are driven and compared when cmd_validH appears. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_puf_cmd_ctrl;

  localparam int MAX_LEN     = 8;
  localparam int MIN_LOW_CYC = 64;
  localparam int TIMEOUT_CYC = 300;
  localparam int LOW         = 70;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  len;
    logic [63:0] chal;
  } cmd_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           rec_data;
  logic                 rec_ready;
  logic                 ack;
  logic                 cmd_validH;
  logic [7:0]           cmd_opH;
  logic [7:0]           cmd_lenH;
  logic [MAX_LEN*8-1:0] challengeH;
  logic                 busyH, err_lenH, err_chkH, err_ovrH, err_toH;

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t exp_q[$];

  puf_cmd_ctrl #(
    .MAX_LEN     (MAX_LEN),
    .MIN_LOW_CYC (MIN_LOW_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk    (clk),
    .sys_rstH   (rst),
    .rec_dataH  (rec_data),
    .rec_readyH (rec_ready),
    .cmd_ackH   (ack),
    .cmd_validH (cmd_validH),
    .cmd_opH    (cmd_opH),
    .cmd_lenH   (cmd_lenH),
    .challengeH (challengeH),
    .busyH      (busyH),
    .err_lenH   (err_lenH),
    .err_chkH   (err_chkH),
    .err_ovrH   (err_ovrH),
    .err_toH    (err_toH)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one byte; the qualified strobe lands on the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int low_cyc);
    @(negedge clk);
    rec_data  = b;
    rec_ready = 1'b0;
    repeat (low_cyc) @(negedge clk);
    rec_ready = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] len,
                            input logic [63:0] pl);
    cmd_t       e;
    logic [7:0] chk;
    chk    = op ^ len;
    e.op   = op;
    e.len  = len;
    e.chal = '0;
    for (int i = 0; i < int'(len); i++) begin
      chk ^= pl[8*i +: 8];
      e.chal[8*i +: 8] = pl[8*i +: 8];
    end
    exp_q.push_back(e);
    send_byte(8'hA5, LOW);
    send_byte(op, LOW);
    send_byte(len, LOW);
    for (int i = 0; i < int'(len); i++) send_byte(pl[8*i +: 8], LOW);
    send_byte(chk, LOW);
  endtask

  task automatic expect_cmd(input string nm);
    cmd_t e;
    bit   seen = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: scoreboard empty, got 0 entries want 1", nm);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_validH;
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_valid: got cmd_validH=0 want 1 within 20 cycles", nm);
    end
    n_checks++;
    if (cmd_opH !== e.op) begin
      n_fail++;
      $display("FAIL %s_op: got %h want %h", nm, cmd_opH, e.op);
    end
    n_checks++;
    if (cmd_lenH !== e.len) begin
      n_fail++;
      $display("FAIL %s_len: got %h want %h", nm, cmd_lenH, e.len);
    end
    n_checks++;
    if (challengeH !== e.chal) begin
      n_fail++;
      $display("FAIL %s_chal: got %h want %h", nm, challengeH, e.chal);
    end
  endtask

  task automatic ack_cmd(input string nm);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if ({cmd_validH, busyH} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_ack: got valid,busy=%b want 00", nm, {cmd_validH, busyH});
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rec_ready = 1'b1;
    rec_data  = 8'h00;
    ack       = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_validH, cmd_opH, cmd_lenH, challengeH, busyH,
         err_lenH, err_chkH, err_ovrH, err_toH} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b op=%h len=%h chal=%h busy=%b errs=%b want all 0",
               cmd_validH, cmd_opH, cmd_lenH, challengeH, busyH,
               {err_lenH, err_chkH, err_ovrH, err_toH});
    end
  endtask

  task automatic test_spurious();
    rec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rec_ready = 1'b1;
    rec_data  = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busyH, cmd_validH} !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_edge: got busy,valid=%b want 00", {busyH, cmd_validH});
    end
  endtask

  task automatic test_basic();
    bit held = 1'b1;
    send_frame(8'h01, 8'h02, 64'h2211);
    expect_cmd("basic");
    repeat (10) begin
      @(negedge clk);
      if (!cmd_validH || cmd_opH !== 8'h01 || challengeH !== 64'h2211) held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL basic_hold: got held=0 want 1");
    end
    ack_cmd("basic");
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if ({busyH, cmd_validH} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ack: got busy,valid=%b want 00", {busyH, cmd_validH});
    end
  endtask

  task automatic test_err_len();
    send_byte(8'hA5, LOW);
    send_byte(8'h01, LOW);
    send_byte(8'h09, LOW);
    @(negedge clk);
    n_checks++;
    if ({err_lenH, busyH} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_len: got err_len,busy=%b want 10", {err_lenH, busyH});
    end
    @(negedge clk);
    n_checks++;
    if (err_lenH !== 1'b0) begin
      n_fail++;
      $display("FAIL err_len_pulse: got %b want 0", err_lenH);
    end
  endtask

  task automatic test_err_chk();
    send_byte(8'hA5, LOW);
    send_byte(8'h01, LOW);
    send_byte(8'h01, LOW);
    send_byte(8'h55, LOW);
    send_byte(8'h00, LOW);
    @(negedge clk);
    n_checks++;
    if ({err_chkH, cmd_validH, busyH} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_chk: got err_chk,valid,busy=%b want 100",
               {err_chkH, cmd_validH, busyH});
    end
  endtask

  task automatic test_noise();
    send_byte(8'hA5, 5);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busyH !== 1'b0) begin
      n_fail++;
      $display("FAIL noise_reject: got busy=%b want 0", busyH);
    end
    send_frame(8'h02, 8'h03, 64'hCC_BB_AA);
    expect_cmd("after_noise");
    ack_cmd("after_noise");
  endtask

  task automatic test_len_bounds();
    send_frame(8'h01, 8'h08, 64'h88776655_44332211);
    expect_cmd("max_len");
    ack_cmd("max_len");
    send_frame(8'h02, 8'h00, 64'h0);
    expect_cmd("zero_len");
    ack_cmd("zero_len");
  endtask

  task automatic test_pend_contention();
    cmd_t e;
    send_frame(8'h01, 8'h01, 64'hC3);
    expect_cmd("pend");
    send_byte(8'h77, LOW);
    @(negedge clk);
    n_checks++;
    if ({err_ovrH, cmd_validH, cmd_opH, cmd_lenH, challengeH} !==
        {1'b1, 1'b1, 8'h01, 8'h01, 64'hC3}) begin
      n_fail++;
      $display("FAIL pend_ovr: got ovr=%b valid=%b op=%h len=%h chal=%h want 1 1 01 01 c3",
               err_ovrH, cmd_validH, cmd_opH, cmd_lenH, challengeH);
    end
    // SYNC strobe and ack on the same edge.
    e.op = 8'h02; e.len = 8'h00; e.chal = '0;
    exp_q.push_back(e);
    @(negedge clk);
    rec_data  = 8'hA5;
    rec_ready = 1'b0;
    repeat (LOW) @(negedge clk);
    rec_ready = 1'b1;
    ack       = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if ({cmd_validH, busyH} !== 2'b01) begin
      n_fail++;
      $display("FAIL ack_sync: got valid,busy=%b want 01", {cmd_validH, busyH});
    end
    send_byte(8'h02, LOW);
    send_byte(8'h00, LOW);
    send_byte(8'h02, LOW);
    expect_cmd("ack_sync");
    ack_cmd("ack_sync");
  endtask

  task automatic test_reset_mid();
    bit err_seen = 1'b0;
    send_byte(8'hA5, LOW);
    send_byte(8'h01, LOW);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      err_seen |= err_lenH | err_chkH | err_ovrH | err_toH;
    end
    n_checks++;
    if ({busyH, err_seen} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: got busy,err=%b want 00", {busyH, err_seen});
    end
    send_frame(8'h01, 8'h02, 64'h5A4B);
    expect_cmd("after_reset");
    ack_cmd("after_reset");
  endtask

  task automatic test_timeout();
    bit saw_to = 1'b0;
    send_byte(8'hA5, LOW);
    send_byte(8'h01, LOW);
`ifdef PUF_CMD_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYC + 50 && !saw_to; i++) begin
      @(negedge clk);
      saw_to = err_toH;
    end
    n_checks++;
    if ({saw_to, busyH} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout: got err_to,busy=%b want 10", {saw_to, busyH});
    end
`else
    repeat (TIMEOUT_CYC + 50) begin
      @(negedge clk);
      saw_to |= err_toH;
    end
    n_checks++;
    if ({saw_to, busyH} !== 2'b01) begin
      n_fail++;
      $display("FAIL no_timeout: got err_to,busy=%b want 01", {saw_to, busyH});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    send_frame(8'h02, 8'h01, 64'h3C);
    expect_cmd("after_timeout");
    ack_cmd("after_timeout");
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_basic();
    test_err_len();
    test_err_chk();
    test_noise();
    test_len_bounds();
    test_pend_contention();
    test_reset_mid();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
